// File: rtl/chain_pkg.sv
// Shared definitions for the AND-OR priority chain and its operand loader.
// Optional feature macro used by the loader: CHAIN_LOADER_PARITY_EN.
package chain_pkg;

  // Number of chain inputs (pi00..pi10) and outputs (po0..po4).
  localparam int CHAIN_N_IN  = 11;
  localparam int CHAIN_N_OUT = 5;

  // Loader FSM states. Encodings are pinned so the debug bus is stable.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } chain_state_e;

  // Even parity over a data word: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [CHAIN_N_IN-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/chain_bit_counter.sv
// Saturating beat counter with synchronous clear; clear wins over increment.
module chain_bit_counter #(
  parameter int               CNT_W = 4,
  parameter logic [CNT_W-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/chain_operand_loader.sv
// Serial-to-parallel operand loader feeding the 11-input AND-OR priority chain.
// Collects one bit per beat into m_vec, holds the complete vector for the
// downstream stage, and drops frames of the wrong length (err_len).
// Optional: define CHAIN_LOADER_PARITY_EN to append an even-parity beat to
// every frame and report parity mismatches on err_par.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and m_vec/m_valid are held
// until the transfer completes (s_ready is low the whole time m_valid is high).
module chain_operand_loader
  import chain_pkg::*;
#(
  parameter int N_IN  = CHAIN_N_IN,
  parameter int CNT_W = $clog2(N_IN + 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_vec,
  output logic            err_len,
`ifdef CHAIN_LOADER_PARITY_EN
  output logic            err_par,
`endif
  output logic [1:0]      dbg_state
);

`ifdef CHAIN_LOADER_PARITY_EN
  localparam int FRAME_LEN = N_IN + 1;
`else
  localparam int FRAME_LEN = N_IN;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(N_IN);

  chain_state_e     state_q;
  chain_state_e     state_d;
  logic [N_IN-1:0]  vec_q;
  logic [N_IN-1:0]  vec_d;
  logic             err_len_q;
  logic             err_len_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             beat;
  logic             wr_en;
  logic             par_ok;
`ifdef CHAIN_LOADER_PARITY_EN
  logic             err_par_q;
  logic             err_par_d;
`endif

  // Ready/valid are pure decodes of the state register, so neither output
  // has a combinational path from any input.
  assign s_ready = (state_q != HOLD);
  assign m_valid = (state_q == HOLD);
  assign beat    = s_valid & s_ready;

  // The parity beat arrives after all data bits are stored, so check it
  // against the stored vector.
`ifdef CHAIN_LOADER_PARITY_EN
  assign par_ok = (even_parity(vec_q) == s_data);
`else
  assign par_ok = 1'b1;
`endif

  chain_bit_counter #(
    .CNT_W (CNT_W),
    .MAX   (LAST_IDX)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt)
  );

  // FSM next state, counter control and one-cycle error pulses; clear overrides all.
  always_comb begin
    state_d   = state_q;
    err_len_d = 1'b0;
`ifdef CHAIN_LOADER_PARITY_EN
    err_par_d = 1'b0;
`endif
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (clear) begin
      state_d = COLLECT;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        COLLECT: begin
          if (beat) begin
            if (cnt == LAST_IDX) begin
              cnt_clr = 1'b1;
              if (s_last) begin
                if (par_ok) begin
                  state_d = HOLD;
                end else begin
`ifdef CHAIN_LOADER_PARITY_EN
                  err_par_d = 1'b1;
`endif
                  state_d = COLLECT;
                end
              end else begin
                // Frame overran: flag once, then swallow the rest of it.
                err_len_d = 1'b1;
                state_d   = DRAIN;
              end
            end else if (s_last) begin
              // Frame ended early: flag and restart collection.
              cnt_clr   = 1'b1;
              err_len_d = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_d = COLLECT;
          end
        end
        DRAIN: begin
          cnt_clr = 1'b1;
          if (beat && s_last) begin
            state_d = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Data beats in COLLECT store their bit; the parity beat is not stored.
  assign wr_en = beat && (state_q == COLLECT) && !clear && (cnt < DATA_LEN);

  // Place the accepted bit at the position given by the beat counter.
  always_comb begin
    vec_d = vec_q;
    if (wr_en) begin
      for (int k = 0; k < N_IN; k++) begin
        if (cnt == CNT_W'(k)) begin
          vec_d[k] = s_data;
        end
      end
    end
  end

  // State, operand vector and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      vec_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_len_q <= err_len_d;
    end
  end

`ifdef CHAIN_LOADER_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_par_q <= 1'b0;
    end else begin
      err_par_q <= err_par_d;
    end
  end

  assign err_par = err_par_q;
`endif

  assign m_vec     = vec_q;
  assign err_len   = err_len_q;
  assign dbg_state = state_q;

endmodule

// File: doc/chain_operand_loader.md
Name: chain_operand_loader

Overview:
- Upstream stage for the 11-input AND-OR priority chain (pi00..pi10 -> po0..po4).
- Receives operand bits serially on a valid/ready stream and assembles them into one N_IN-bit vector.
- Holds the vector stable and presents it on a valid/ready master interface, so the combinational chain always sees a complete, glitch-free operand set.
- Rejects malformed frames and reports the error.

Parameters:
- N_IN, 11, bits per frame; bit k drives chain input pi<k> (pi00 first).
- CNT_W, $clog2(N_IN+2), width of the internal bit counter (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; drops any partial or held frame.
- s_valid  in  1  serial bit valid.
- s_ready  out  1  loader accepts the serial bit this cycle.
- s_data  in  1  serial operand bit.
- s_last  in  1  marks the final bit of a frame.
- m_valid  out  1  m_vec holds a complete frame.
- m_ready  in  1  downstream consumes m_vec.
- m_vec  out  N_IN  assembled operands; bit k = k-th accepted bit.
- err_len  out  1  one-cycle pulse when a frame is dropped for bad length.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=COLLECT, count=0, m_vec=0, m_valid=0, err_len=0. s_ready=1 after reset is released.
- Beat rule: a beat is s_valid & s_ready.
- States:
  - COLLECT: s_ready=1, m_valid=0.
    - Each beat writes s_data into m_vec[count] and increments count.
    - Beat with count==N_IN-1 and s_last=1 -> HOLD; count=0.
    - Beat with s_last=1 and count<N_IN-1 (short frame) -> err_len pulse next cycle; stay in COLLECT; count=0.
    - Beat with count==N_IN-1 and s_last=0 (long frame) -> err_len pulse next cycle; go to DRAIN; count=0.
  - HOLD: s_ready=0, m_valid=1.
    - m_vec is frozen.
    - m_valid & m_ready -> COLLECT on the next cycle. One bubble cycle follows; s_ready rises the cycle after the transfer.
  - DRAIN: s_ready=1, m_valid=0.
    - Beats are discarded.
    - Beat with s_last=1 -> COLLECT, count=0. No further err_len.
- Latency: m_valid rises one cycle after the final accepted beat.
- m_vec contents: unchanged outside COLLECT beats. Stale bits from a dropped frame may remain but are never presented with m_valid=1. A new frame overwrites every bit.
- clear: has priority over all other events. Next state=COLLECT, count=0, m_valid=0, err_len=0. m_vec is not reset.
- Simultaneous events:
  - clear together with m_ready in HOLD: the frame counts as consumed by downstream. The loader does not retry.
  - s_valid asserted in HOLD: ignored, because s_ready=0.
- Asynchronous reset mid-frame: returns to the reset values immediately. Partial bits are lost.
- err_len never asserts for two consecutive cycles from the same frame.

Optional Feature:
- Macro: CHAIN_LOADER_PARITY_EN.
- Defined:
  - Frame length is N_IN+1 beats; the extra final beat is an even-parity bit over the N_IN data bits.
  - Parity mismatch: frame goes to COLLECT instead of HOLD. err_par (extra output port, 1 bit, reset 0) pulses for one cycle.
  - Length rules apply to N_IN+1.
- Undefined: no parity beat and no err_par port. Frame length is N_IN.

Decomposition:
- Shared package chain_pkg:
  - state enum {COLLECT, HOLD, DRAIN}.
  - localparam CHAIN_N_IN=11.
  - localparam CHAIN_N_OUT=5.
- Sub-module: none required. The single FSM plus counter fits in one module.
- Natural optional split: chain_bit_counter (saturating CNT_W counter with clear). Acceptable but not mandated.

Test Plan:
- Nominal frame:
  - Stimulus: reset; send 11 beats of bits 1,0,0,0,1,0,0,0,0,0,0 (pi00=1, pi04=1) with s_last on beat 11; m_ready=1.
  - Response: m_valid=1 one cycle after beat 11; m_vec=11'h011; consumed the same cycle; s_ready=1 two cycles after the last beat.
- Backpressure:
  - Stimulus: complete frame 11'h7FF; hold m_ready=0 for 5 cycles; keep s_valid=1.
  - Response: s_ready=0 and m_vec=11'h7FF stable for all 5 cycles; transfer on the cycle m_ready=1.
- Short frame:
  - Stimulus: s_last on beat 6.
  - Response: err_len pulses for exactly 1 cycle; m_valid stays 0; the next 11-beat frame 11'h400 is presented correctly.
- Long frame:
  - Stimulus: 14 beats with s_last only on beat 14.
  - Response: err_len pulses once after beat 11; beats 12-14 are discarded; the following good frame is accepted.
- Clear and reset:
  - Stimulus: clear asserted in HOLD with m_ready=0.
  - Response: m_valid=0 the next cycle.
  - Stimulus: rst_n low after beat 7.
  - Response: m_valid=0, s_ready=1 after release; a new 11-beat frame is assembled from bit 0.
- Parity (CHAIN_LOADER_PARITY_EN):
  - Stimulus: 11'h011 with parity beat 1 (wrong).
  - Response: err_par pulses and no m_valid.
  - Stimulus: same frame with parity beat 0.
  - Response: frame is presented.
